// File: rtl/acc_pkg.sv
// Shared types and constants for the signed accumulator slice.
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } acc_state_t;

  localparam int ACC_WIDTH = 8;
  localparam int CNT_WIDTH = 4;

  // Signed saturation limits at ACC_WIDTH bits.
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

endpackage

// File: rtl/acc_add_ovf.sv
// Combinational signed adder with overflow detect.
// Optional macro ACC_SATURATE_EN: clamp to the signed limit on overflow
// instead of two's-complement wrap-around.
module acc_add_ovf #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] op,
  output logic [WIDTH-1:0] sum,
  output logic             ovf_now
);

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] raw;

  // Add, detect same-sign overflow, optionally saturate.
  always_comb begin
    raw     = acc + op;
    ovf_now = (acc[WIDTH-1] == op[WIDTH-1]) && (raw[WIDTH-1] != acc[WIDTH-1]);
`ifdef ACC_SATURATE_EN
    if (ovf_now) begin
      sum = op[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end else begin
      sum = raw;
    end
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/signed_acc_register.sv
// Signed accumulator stage with valid/ready handshake, sticky overflow
// flag and wrapping operation counter. Saturation is selected by the
// ACC_SATURATE_EN macro inside acc_add_ovf.
module signed_acc_register
  import acc_pkg::*;
#(
  parameter int WIDTH     = acc_pkg::ACC_WIDTH,
  parameter int CNT_WIDTH = acc_pkg::CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     acc_out,
  output logic                 zero,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] op_count
);

  acc_state_t           state_q;
  acc_state_t           state_d;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     op_reg;
  logic [WIDTH-1:0]     sum;
  logic                 ovf_now;

  acc_add_ovf #(.WIDTH(WIDTH)) u_add (
    .acc     (acc),
    .op      (op_reg),
    .sum     (sum),
    .ovf_now (ovf_now)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; clear overrides everything.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = !clear;
        if (in_valid && !clear) state_d = CALC;
      end
      CALC: state_d = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d   = IDLE;
    end
  end

  // Datapath registers: operand capture, accumulate, flags, counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      op_reg   <= '0;
      overflow <= 1'b0;
      op_count <= '0;
    end else if (clear) begin
      acc      <= '0;
      overflow <= 1'b0;
      op_count <= '0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        op_reg <= in_data;
      end
      if (state_q == CALC) begin
        acc      <= sum;
        overflow <= overflow | ovf_now;
        op_count <= op_count + 1'b1;
      end
    end
  end

  assign acc_out = acc;
  assign zero    = (acc == '0);

endmodule

// File: tb/tb_signed_acc_register.sv
// Scoreboard bench for signed_acc_register: the driver pushes expected
// results, the monitor pops and compares on each output handshake.
module tb_signed_acc_register;
  import acc_pkg::*;

  typedef struct {
    logic [7:0] acc;
    logic       zero;
    logic       ovf;
    logic [3:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] acc_out;
  logic       zero;
  logic       overflow;
  logic [3:0] op_count;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  signed_acc_register #(.WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .zero      (zero),
    .overflow  (overflow),
    .op_count  (op_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one compare per accepted output beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: acc=0x%0h with empty scoreboard", acc_out);
        end else begin
          e = exp_q.pop_front();
          chk("acc_out",  {24'd0, acc_out},  {24'd0, e.acc});
          chk("zero",     {31'd0, zero},     {31'd0, e.zero});
          chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
          chk("op_count", {28'd0, op_count}, {28'd0, e.cnt});
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: in_ready=0 expected 1");
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] ea, input logic eo, input logic [3:0] ec);
    exp_t e;
    wait_ready();
    e.acc = ea;
    e.zero = (ea == 8'h00);
    e.ovf = eo;
    e.cnt = ec;
    exp_q.push_back(e);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h5A;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d pending expected 0", exp_q.size());
    end
    wait_ready();
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_acc",       {24'd0, acc_out},   32'h00);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_zero",      {31'd0, zero},      32'd1);
    chk("rst_ovf",       {31'd0, overflow},  32'd0);
    chk("rst_cnt",       {28'd0, op_count},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Add then cancel with the negated operand
    send(8'h36, 8'h36, 1'b0, 4'd1);
    send(8'hCA, 8'h00, 1'b0, 4'd2);

    // Positive overflow, then sticky flag
    send(8'h7F, 8'h7F, 1'b0, 4'd3);
`ifdef ACC_SATURATE_EN
    send(8'h01, ACC_MAX, 1'b1, 4'd4);
    send(8'hFF, 8'h7E, 1'b1, 4'd5);
`else
    send(8'h01, 8'h80, 1'b1, 4'd4);
    send(8'hFF, 8'h7F, 1'b1, 4'd5);
`endif
    drain();

    // Backpressure
    pulse_clear();
    chk("clr_ovf", {31'd0, overflow}, 32'd0);
    chk("clr_cnt", {28'd0, op_count}, 32'd0);
    out_ready = 1'b0;
    send(8'h05, 8'h05, 1'b0, 4'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
      chk("bp_acc",       {24'd0, acc_out},   32'h05);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_rel_in_ready",  {31'd0, in_ready},  32'd1);
    chk("bp_rel_out_valid", {31'd0, out_valid}, 32'd0);
    drain();

    // clear colliding with in_valid
    pulse_clear();
    send(8'h08, 8'h08, 1'b0, 4'd1);
    send(8'h04, 8'h0C, 1'b0, 4'd2);
    send(8'h04, 8'h10, 1'b0, 4'd3);
    drain();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h22;
    #1;
    chk("clr_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("clr2_acc",       {24'd0, acc_out},   32'h00);
    chk("clr2_cnt",       {28'd0, op_count},  32'd0);
    chk("clr2_ovf",       {31'd0, overflow},  32'd0);
    chk("clr2_in_ready",  {31'd0, in_ready},  32'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("clr2_no_accept", {31'd0, out_valid}, 32'd0);

    // Reset mid-CALC
    send(8'h20, 8'h20, 1'b0, 4'd1);
    drain();
    in_valid = 1'b1;
    in_data  = 8'h33;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_acc",       {24'd0, acc_out},   32'h00);
    chk("arst_cnt",       {28'd0, op_count},  32'd0);
    chk("arst_zero",      {31'd0, zero},      32'd1);
    chk("arst_in_ready",  {31'd0, in_ready},  32'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Counter wrap over 16 additions
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] ea;
      logic [3:0] ec;
      ea = 8'(i);
      ec = 4'(i);
      send(8'h01, ea, 1'b0, ec);
    end
    drain();
    chk("wrap_acc", {24'd0, acc_out},  32'h10);
    chk("wrap_cnt", {28'd0, op_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/signed_acc_register.md
Name: signed_acc_register

Overview:
- Sequential stage directly downstream of the `negative` stage: consumes its 8-bit two's-complement `result`.
- Adds each accepted operand into a signed accumulator register. Subtraction is performed as addition of the negated operand.
- Exposes accumulator value, status flags and an operation counter behind a valid/ready handshake. The register-bank write port is the consumer.

Parameters:
- WIDTH, 8, data/accumulator width in bits (signed two's complement).
- CNT_WIDTH, 4, width of the accepted-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of accumulator, flags, counter and FSM.
- in_valid  input  1  operand available (driven alongside `negative.result`).
- in_ready  output  1  stage can accept an operand.
- in_data  input  WIDTH  operand, signed; wired to `negative.result`.
- out_valid  output  1  updated accumulator available.
- out_ready  input  1  consumer accepts `acc_out`.
- acc_out  output  WIDTH  accumulator value.
- zero  output  1  acc_out == 0.
- overflow  output  1  sticky signed-overflow flag.
- op_count  output  CNT_WIDTH  number of completed additions, modulo 2^CNT_WIDTH.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, acc=0, op_reg=0, overflow=0, op_count=0, out_valid=0. After reset, in_ready=1 and zero=1.
- FSM states: IDLE, CALC, OUT.
- IDLE:
  - in_ready=1 unless clear=1.
  - On in_valid&&in_ready: op_reg<=in_data; go to CALC.
- CALC (one cycle, in_ready=0):
  - sum = acc + op_reg, computed at WIDTH bits.
  - ovf_now = (acc[MSB]==op_reg[MSB]) && (sum[MSB]!=acc[MSB]).
  - acc<=sum; overflow<=overflow|ovf_now; op_count<=op_count+1 (wraps); go to OUT.
- OUT:
  - out_valid=1; acc_out stable.
  - On out_ready: go to IDLE; out_valid deasserts the next cycle.
  - Stays in OUT indefinitely under backpressure; in_ready=0 throughout.
- Latency: operand accepted at edge N; acc updated and out_valid=1 at edge N+1. With out_ready=1, the next operand can be accepted at edge N+3 (throughput 1 per 3 cycles).
- Outputs: acc_out=acc always (not gated by out_valid); zero combinational from acc.
- clear (synchronous, highest priority below reset):
  - acc=0, overflow=0, op_count=0, state=IDLE, out_valid=0.
  - An in-flight operand in CALC is discarded; no count increment.
  - in_ready is forced 0 while clear=1, so a simultaneous in_valid is not accepted.
- in_data is ignored when not handshaking; op_reg holds the captured value through CALC.
- Reset asserted mid-CALC or mid-OUT: immediate return to reset values; pending result lost.
- Counter wrap: after 2^CNT_WIDTH operations op_count returns to 0. overflow is unaffected by the wrap.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined:
  - On ovf_now, acc is clamped to the signed limit instead of wrapping: 0x7F if op_reg is non-negative, 0x80 if negative (for WIDTH=8).
  - The overflow flag is still set.
- Undefined: plain two's-complement wrap-around.

Decomposition:
- Shared package acc_pkg holds:
  - state enum {IDLE, CALC, OUT};
  - constants ACC_WIDTH=8 and CNT_WIDTH=4;
  - the ACC_MAX/ACC_MIN saturation limits.
- One natural sub-module, acc_add_ovf: combinational WIDTH-bit adder returning sum and ovf_now, with saturation selected under ACC_SATURATE_EN. The FSM, registers and handshake stay in signed_acc_register.

Test Plan:
- After reset: push in_data=0x36, out_ready=1 -> at edge N+1 acc_out=0x36, out_valid=1, op_count=1, zero=0, overflow=0.
- Then push 0xCA (`negative` of 0x36) -> acc_out=0x00, zero=1, op_count=2, overflow=0.
- From acc=0: push 0x7F then 0x01 -> acc_out=0x80 with overflow=1. With ACC_SATURATE_EN: acc_out=0x7F, overflow=1. Then push 0xFF -> overflow stays 1 (sticky).
- Backpressure: hold out_ready=0 for 5 cycles after an add -> out_valid=1 and in_ready=0 for all 5 cycles, acc_out constant. Releasing out_ready -> IDLE, in_ready=1 the following cycle.
- clear asserted in the same cycle as in_valid=1 with acc=0x10, op_count=3 -> operand not accepted; next cycle acc=0, op_count=0, overflow=0, state IDLE.
- rst_n pulsed low mid-CALC -> outputs return to reset values immediately (asynchronous). Also: 16 consecutive additions of 0x01 from 0 -> acc_out=0x10, op_count=0.
